// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, condition functions, status codes,
// register "none" ID and the pipeline status FSM state type.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [1:0] SAOK = 2'b00;
    localparam logic [1:0] SHLT = 2'b01;
    localparam logic [1:0] SADR = 2'b10;
    localparam logic [1:0] SINS = 2'b11;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pstate_e;

endpackage

// File: rtl/cond_eval.sv
// Condition evaluation for cmovXX/jXX from a {ZF,SF,OF} flag vector.
// Unknown condition functions evaluate false.
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf;
    logic sf;
    logic of;

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];

    // Decode the condition function against the flags
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = (sf ^ of) | zf;
            C_L:     cnd = sf ^ of;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~(sf ^ of);
            C_G:     cnd = ~(sf ^ of) & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: CC register, hazard stall/bubble generation
// and status FSM. Optional counters are enabled by PIPE_PERF_CNT_EN.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter logic [2:0] CC_RESET = 3'b100,
    parameter int         CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_ifun,
    input  logic [3:0] E_dstM,
    input  logic [3:0] M_icode,
    input  logic       alu_zf,
    input  logic       alu_sf,
    input  logic       alu_of,
    input  logic [1:0] m_stat,
    input  logic [1:0] W_stat,
    output logic [2:0] cc,
    output logic       e_cnd,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic       M_bubble,
    output logic       W_stall,
    output logic       halted,
    output logic [1:0] stat_out
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    pstate_e    state_q;
    pstate_e    state_d;
    logic [2:0] cc_q;
    logic [2:0] cc_d;
    logic [1:0] stat_q;
    logic [1:0] stat_d;

    logic cnd_raw;
    logic cnd_ok;
    logic set_cc;
    logic load_use;
    logic ret_in_pipe;
    logic mispredict;
    logic m_bad;
    logic w_bad;

    cond_eval u_cond (
        .cc   (cc_q),
        .ifun (E_ifun),
        .cnd  (cnd_raw)
    );

    assign cnd_ok = (E_icode == IRRMOVQ) || (E_icode == IJXX);
    assign e_cnd  = cnd_ok & cnd_raw;

    assign m_bad = (m_stat != SAOK);
    assign w_bad = (W_stat != SAOK);

    assign set_cc = (E_icode == IOPQ) && (state_q == RUN)
                  && !m_bad && !w_bad;

    assign load_use = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ))
                    && (E_dstM != REG_NONE)
                    && ((E_dstM == d_srcA) || (E_dstM == d_srcB));

    assign ret_in_pipe = (D_icode == IRET) || (E_icode == IRET)
                       || (M_icode == IRET);

    assign mispredict = (E_icode == IJXX) && !e_cnd;

    // Status FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Status FSM next-state: drain on a memory fault, halt at write-back
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (w_bad) begin
                    state_d = HALTED;
                end else if (m_bad) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_bad) begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Status FSM outputs: hazard controls while live, freeze when halted
    always_comb begin
        halted   = 1'b0;
        F_stall  = load_use | ret_in_pipe;
        D_stall  = load_use;
        D_bubble = mispredict | (ret_in_pipe & ~load_use);
        E_bubble = mispredict | load_use;
        M_bubble = m_bad | w_bad;
        W_stall  = w_bad;
        if (state_q == HALTED) begin
            halted   = 1'b1;
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b0;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
        end
    end

    // Next CC and captured final status
    always_comb begin
        cc_d   = cc_q;
        stat_d = stat_q;
        if (set_cc) begin
            cc_d = {alu_zf, alu_sf, alu_of};
        end
        if ((state_q != HALTED) && w_bad) begin
            stat_d = W_stat;
        end
    end

    // CC and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q   <= CC_RESET;
            stat_q <= SAOK;
        end else begin
            cc_q   <= cc_d;
            stat_q <= stat_d;
        end
    end

    assign cc       = cc_q;
    assign stat_out = stat_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] cyc_d;
    logic [CNT_W-1:0] stl_q;
    logic [CNT_W-1:0] stl_d;

    // Saturating cycle and fetch-stall counters, idle once halted
    always_comb begin
        cyc_d = cyc_q;
        stl_d = stl_q;
        if (state_q != HALTED) begin
            if (cyc_q != {CNT_W{1'b1}}) begin
                cyc_d = cyc_q + 1'b1;
            end
            if (F_stall && (stl_q != {CNT_W{1'b1}})) begin
                stl_d = stl_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            stl_q <= stl_d;
        end
    end

    assign cycle_cnt = cyc_q;
    assign stall_cnt = stl_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: condition codes, hazards, status FSM
// and asynchronous reset from the halted state.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] D_icode;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    logic [3:0] E_icode;
    logic [3:0] E_ifun;
    logic [3:0] E_dstM;
    logic [3:0] M_icode;
    logic       alu_zf;
    logic       alu_sf;
    logic       alu_of;
    logic [1:0] m_stat;
    logic [1:0] W_stat;
    logic [2:0] cc;
    logic       e_cnd;
    logic       F_stall;
    logic       D_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       M_bubble;
    logic       W_stall;
    logic       halted;
    logic [1:0] stat_out;

    int total;
    int passes;
    int fails;

    pipe_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .D_icode  (D_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_icode  (E_icode),
        .E_ifun   (E_ifun),
        .E_dstM   (E_dstM),
        .M_icode  (M_icode),
        .alu_zf   (alu_zf),
        .alu_sf   (alu_sf),
        .alu_of   (alu_of),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .cc       (cc),
        .e_cnd    (e_cnd),
        .F_stall  (F_stall),
        .D_stall  (D_stall),
        .D_bubble (D_bubble),
        .E_bubble (E_bubble),
        .M_bubble (M_bubble),
        .W_stall  (W_stall),
        .halted   (halted),
        .stat_out (stat_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall}
    function automatic logic [7:0] ctl();
        return {2'b00, F_stall, D_stall, D_bubble,
                E_bubble, M_bubble, W_stall};
    endfunction

    task automatic idle();
        D_icode = 4'h1;
        E_icode = 4'h1;
        M_icode = 4'h1;
        E_ifun  = 4'h0;
        E_dstM  = 4'hF;
        d_srcA  = 4'hF;
        d_srcB  = 4'hF;
        alu_zf  = 1'b0;
        alu_sf  = 1'b0;
        alu_of  = 1'b0;
        m_stat  = 2'b00;
        W_stat  = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passes = 0;
        fails  = 0;
        rst    = 1'b1;
        idle();
        #3;
        chk("rst_cc", {5'd0, cc}, 8'h04);
        chk("rst_ctl", ctl(), 8'h00);
        chk("rst_halted", {7'd0, halted}, 8'h00);
        chk("rst_stat", {6'd0, stat_out}, 8'h00);
        chk("rst_cnd", {7'd0, e_cnd}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_cc", {5'd0, cc}, 8'h04);
        chk("idle_ctl", ctl(), 8'h00);

        // OPq sets flags zf=0 sf=1 of=0
        E_icode = 4'h6;
        alu_sf  = 1'b1;
        #1;
        chk("opq_cc_before", {5'd0, cc}, 8'h04);
        tick();
        chk("opq_cc", {5'd0, cc}, 8'h02);
        E_icode = 4'h7;
        E_ifun  = 4'h2;
        alu_sf  = 1'b0;
        #1;
        chk("jl_cnd", {7'd0, e_cnd}, 8'h01);
        chk("jl_ctl", ctl(), 8'h00);
        E_ifun = 4'h3;
        #1;
        chk("je_cnd", {7'd0, e_cnd}, 8'h00);
        chk("je_ctl", ctl(), 8'h0C);
        E_ifun = 4'h0;
        #1;
        chk("jmp_cnd", {7'd0, e_cnd}, 8'h01);
        E_ifun = 4'h7;
        #1;
        chk("j7_cnd", {7'd0, e_cnd}, 8'h00);
        E_ifun = 4'h6;
        #1;
        chk("jg_cnd", {7'd0, e_cnd}, 8'h00);
        E_icode = 4'h2;
        E_ifun  = 4'h4;
        #1;
        chk("cmovne_cnd", {7'd0, e_cnd}, 8'h01);
        chk("cmovne_ctl", ctl(), 8'h00);
        E_icode = 4'h3;
        #1;
        chk("irmov_cnd", {7'd0, e_cnd}, 8'h00);
        tick();
        chk("cc_hold", {5'd0, cc}, 8'h02);

        // Load-use
        idle();
        E_icode = 4'h5;
        E_dstM  = 4'h3;
        d_srcA  = 4'h3;
        #1;
        chk("lu_mr_ctl", ctl(), 8'h34);
        E_icode = 4'hB;
        d_srcA  = 4'hF;
        d_srcB  = 4'h3;
        #1;
        chk("lu_pop_ctl", ctl(), 8'h34);
        d_srcB = 4'hF;
        #1;
        chk("lu_none_ctl", ctl(), 8'h00);
        E_dstM = 4'hF;
        #1;
        chk("lu_dstnone_ctl", ctl(), 8'h00);

        // ret in pipe
        idle();
        D_icode = 4'h9;
        #1;
        chk("ret_d_ctl", ctl(), 8'h28);
        E_icode = 4'h5;
        E_dstM  = 4'h3;
        d_srcA  = 4'h3;
        #1;
        chk("ret_lu_ctl", ctl(), 8'h34);
        idle();
        M_icode = 4'h9;
        #1;
        chk("ret_m_ctl", ctl(), 8'h28);

        // Memory fault drains, write-back fault halts
        idle();
        E_icode = 4'h6;
        alu_zf  = 1'b1;
        alu_of  = 1'b1;
        m_stat  = 2'b10;
        #1;
        chk("mbad_ctl", ctl(), 8'h02);
        tick();
        chk("drain_cc", {5'd0, cc}, 8'h02);
        chk("drain_halted", {7'd0, halted}, 8'h00);
        E_icode = 4'h5;
        E_dstM  = 4'h3;
        d_srcA  = 4'h3;
        #1;
        chk("drain_lu_ctl", ctl(), 8'h36);
        E_icode = 4'h6;
        E_dstM  = 4'hF;
        d_srcA  = 4'hF;
        m_stat  = 2'b00;
        tick();
        chk("drain_cc_frozen", {5'd0, cc}, 8'h02);
        chk("drain_stat", {6'd0, stat_out}, 8'h00);
        E_icode = 4'h1;
        W_stat  = 2'b10;
        #1;
        chk("wbad_ctl", ctl(), 8'h03);
        tick();
        chk("halt_halted", {7'd0, halted}, 8'h01);
        chk("halt_stat", {6'd0, stat_out}, 8'h02);
        chk("halt_ctl", ctl(), 8'h33);
        idle();
        E_icode = 4'h7;
        E_ifun  = 4'h3;
        #1;
        chk("halt_misp_ctl", ctl(), 8'h33);
        E_icode = 4'h6;
        alu_zf  = 1'b1;
        tick();
        tick();
        chk("halt_sticky", {7'd0, halted}, 8'h01);
        chk("halt_stat_hold", {6'd0, stat_out}, 8'h02);
        chk("halt_cc_frozen", {5'd0, cc}, 8'h02);

        // Async reset while halted
        #1;
        rst = 1'b1;
        #1;
        chk("arst_halted", {7'd0, halted}, 8'h00);
        chk("arst_cc", {5'd0, cc}, 8'h04);
        chk("arst_stat", {6'd0, stat_out}, 8'h00);
        idle();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_ctl", ctl(), 8'h00);
        chk("post_rst_halted", {7'd0, halted}, 8'h00);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
